// File: rtl/array_sequencer_pkg.sv
// Shared constants for the PE-grid sequencer: grid-wide state codes and FSM states.
package array_sequencer_pkg;

  // global_state codes decoded by every PE
  localparam logic [1:0] S_LOAD_W = 2'd0;  // also the hold code when cfg_valid is low
  localparam logic [1:0] S_LOAD_X = 2'd1;
  localparam logic [1:0] S_MAC    = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  // Sequencer FSM states
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t StIdle  = 3'd0;
  localparam seq_state_t StWload = 3'd1;
  localparam seq_state_t StXload = 3'd2;
  localparam seq_state_t StClr   = 3'd3;
  localparam seq_state_t StMac   = 3'd4;
  localparam seq_state_t StDone  = 3'd5;

endpackage

// File: rtl/array_sequencer.sv
// Feed/control stage for the PE grid: streams weights into the grid config bus, shifts
// activations in at the left edge, then clears and runs the MAC wavefront.
// Grid-facing outputs lag the FSM by one register stage.
module array_sequencer
  import array_sequencer_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned ROW_W = 4,
  parameter int unsigned COL_W = 4,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_reuse_w,
  output logic                   o_busy,
  output logic                   o_done,
  input  logic                   i_w_valid,
  output logic                   o_w_ready,
  input  logic [DW-1:0]          i_w_data,
  input  logic                   i_x_valid,
  output logic                   o_x_ready,
  input  logic [ROWS*DW-1:0]     i_x_data,
  output logic [ROW_W+COL_W-1:0] o_cfg_addr,
  output logic [DW-1:0]          o_cfg_data,
  output logic                   o_cfg_valid,
  output logic [1:0]             o_global_state,
  output logic [ROWS*DW-1:0]     o_x_edge
);

  localparam int unsigned PhMax = (COLS > ROWS) ? COLS : ROWS;
  localparam int unsigned PhW   = $clog2(PhMax) + 1;

  seq_state_t r_state;
  seq_state_t w_state_next;

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [PhW-1:0]   r_ph;

  logic                   r_busy;
  logic                   r_done;
  logic                   r_w_ready;
  logic                   r_x_ready;
  logic [ROW_W+COL_W-1:0] r_cfg_addr;
  logic [DW-1:0]          r_cfg_data;
  logic                   r_cfg_valid;
  logic [1:0]             r_gs;
  logic [ROWS*DW-1:0]     r_x_edge;

  logic       w_w_hs;
  logic       w_x_hs;
  logic       w_last_w;
  logic       w_last_x;
  logic       w_last_mac;
  logic [1:0] w_gs_next;

  // ready registers are only high in their own phase, so these are phase-qualified
  assign w_w_hs     = r_w_ready & i_w_valid;
  assign w_x_hs     = r_x_ready & i_x_valid;
  assign w_last_w   = (r_row == ROW_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1));
  assign w_last_x   = (r_ph == PhW'(COLS - 1));
  assign w_last_mac = (r_ph == PhW'(ROWS - 1));

  // Next FSM state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = i_reuse_w ? StXload : StWload;
      StWload: if (w_w_hs && w_last_w) w_state_next = StXload;
      StXload: if (w_x_hs && w_last_x) w_state_next = StClr;
      StClr:   w_state_next = StMac;
      StMac:   if (w_last_mac) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Grid state code to present in the following cycle
  always_comb begin
    w_gs_next = S_LOAD_W;
    case (r_state)
      StXload: if (w_x_hs) w_gs_next = S_LOAD_X;
      StClr:   w_gs_next = S_CLEAR;
      StMac:   w_gs_next = S_MAC;
      default: w_gs_next = S_LOAD_W;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_ready   <= 1'b0;
      r_x_ready   <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_cfg_valid <= 1'b0;
      r_gs        <= S_LOAD_W;
      r_x_edge    <= '0;
    end else begin
      r_state     <= w_state_next;
      // busy stays up through the done pulse, which is emitted after leaving StDone
      r_busy      <= (w_state_next != StIdle) || (r_state == StDone);
      r_done      <= (r_state == StDone);
      r_w_ready   <= (w_state_next == StWload);
      r_x_ready   <= (w_state_next == StXload);
      r_cfg_valid <= w_w_hs;
      r_gs        <= w_gs_next;
      if (w_w_hs) begin
        r_cfg_addr <= {r_row, r_col};
        r_cfg_data <= i_w_data;
      end
      if (w_x_hs) r_x_edge <= i_x_data;
    end
  end

  // Weight position and phase counters; both return to zero at the end of their phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_ph  <= '0;
    end else begin
      if (w_w_hs) begin
        if (r_col == COL_W'(COLS - 1)) begin
          r_col <= '0;
          r_row <= w_last_w ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      case (r_state)
        StXload: if (w_x_hs) r_ph <= w_last_x ? '0 : r_ph + PhW'(1);
        StMac:   r_ph <= w_last_mac ? '0 : r_ph + PhW'(1);
        default: r_ph <= '0;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_w_ready      = r_w_ready;
  assign o_x_ready      = r_x_ready;
  assign o_cfg_addr     = r_cfg_addr;
  assign o_cfg_data     = r_cfg_data;
  assign o_cfg_valid    = r_cfg_valid;
  assign o_global_state = r_gs;
  assign o_x_edge       = r_x_edge;

endmodule

// File: tb/tb_array_sequencer.sv
// Self-checking bench for array_sequencer on a 2x2 grid: a hand-derived vector table,
// randomized passes against a cycle-indexed protocol model, and reset/start-hold sequences.
module tb_array_sequencer;

  localparam int DW = 8;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int XW = ROWS * DW;
  localparam int AW = ROW_W + COL_W;
  localparam int NMAX = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, reuse_w;
  logic          busy, done;
  logic          w_valid, w_ready;
  logic [DW-1:0] w_data;
  logic          x_valid, x_ready;
  logic [XW-1:0] x_data;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic [1:0]    global_state;
  logic [XW-1:0] x_edge;

  int n_checks = 0;
  int n_fail = 0;

  array_sequencer #(
    .DW(DW), .ROW_W(ROW_W), .COL_W(COL_W), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_reuse_w(reuse_w),
    .o_busy(busy), .o_done(done),
    .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_data(w_data),
    .i_x_valid(x_valid), .o_x_ready(x_ready), .i_x_data(x_data),
    .o_cfg_addr(cfg_addr), .o_cfg_data(cfg_data), .o_cfg_valid(cfg_valid),
    .o_global_state(global_state), .o_x_edge(x_edge)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic s; logic wv; logic [7:0] wd; logic xv; logic [15:0] xd;
    logic b; logic d; logic wr; logic xr; logic cv;
    logic [7:0] a; logic [7:0] cd; logic [1:0] g; logic [15:0] xe;
  } vec_t;

  function automatic vec_t mk(logic s, logic wv_, logic [7:0] wd_, logic xv_, logic [15:0] xd_,
                              logic b, logic d, logic wr, logic xr, logic cv, logic [7:0] a,
                              logic [7:0] cd, logic [1:0] g, logic [15:0] xe);
    vec_t v;
    v.s = s; v.wv = wv_; v.wd = wd_; v.xv = xv_; v.xd = xd_;
    v.b = b; v.d = d; v.wr = wr; v.xr = xr; v.cv = cv; v.a = a; v.cd = cd; v.g = g; v.xe = xe;
    return v;
  endfunction

  // ---------------- behavioural model (expected trace per cycle of a pass) ----------------
  logic          e_busy [NMAX], e_done [NMAX], e_wrdy [NMAX], e_xrdy [NMAX], e_cfgv [NMAX];
  logic [AW-1:0] e_addr [NMAX];
  logic [DW-1:0] e_data [NMAX];
  logic [1:0]    e_gs   [NMAX];
  logic [XW-1:0] e_xedge[NMAX];
  logic          wv [NMAX], xv [NMAX];
  logic [DW-1:0] wd [NMAX];
  logic [XW-1:0] xd [NMAX];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [XW-1:0] m_xedge;

  // Cycle 0 is the start cycle; each accepted beat shows on the grid outputs one cycle later.
  task automatic build_model(input bit reuse, input int stall, output int len);
    int t, n, m;
    logic          wr_at [NMAX];
    logic [AW-1:0] wr_a  [NMAX];
    logic [DW-1:0] wr_d  [NMAX];
    logic          xe_at [NMAX];
    logic [XW-1:0] xe_v  [NMAX];
    for (int k = 0; k < NMAX; k++) begin
      e_busy[k] = 0; e_done[k] = 0; e_wrdy[k] = 0; e_xrdy[k] = 0; e_cfgv[k] = 0; e_gs[k] = 0;
      wv[k] = 0; xv[k] = 0; wd[k] = DW'($urandom); xd[k] = XW'($urandom);
      wr_at[k] = 0; xe_at[k] = 0; wr_a[k] = 0; wr_d[k] = 0; xe_v[k] = 0;
    end
    t = 1;
    if (!reuse) begin
      n = 0;
      while (n < ROWS * COLS) begin
        e_wrdy[t] = 1;
        wv[t] = (stall == 0) || ($urandom_range(99) >= stall) || (t > 100);
        if (wv[t]) begin
          e_cfgv[t+1] = 1;
          wr_at[t+1] = 1;
          wr_a[t+1] = {ROW_W'(n / COLS), COL_W'(n % COLS)};
          wr_d[t+1] = wd[t];
          n++;
        end
        t++;
      end
    end
    m = 0;
    while (m < COLS) begin
      e_xrdy[t] = 1;
      xv[t] = (stall == 0) || ($urandom_range(99) >= stall) || (t > 150);
      if (xv[t]) begin
        e_gs[t+1] = 2'd1;
        xe_at[t+1] = 1;
        xe_v[t+1] = xd[t];
        m++;
      end
      t++;
    end
    e_gs[t+1] = 2'd3;  // clear cycle
    t++;
    for (int r = 0; r < ROWS; r++) begin
      e_gs[t+1] = 2'd2;
      t++;
    end
    t++;               // DONE state cycle; done shows one cycle later
    len = t;
    e_done[len] = 1;
    for (int k = 1; k <= len; k++) e_busy[k] = 1;
    for (int k = 0; k <= len + 1; k++) begin
      if (wr_at[k]) begin m_addr = wr_a[k]; m_data = wr_d[k]; end
      if (xe_at[k]) m_xedge = xe_v[k];
      e_addr[k] = m_addr; e_data[k] = m_data; e_xedge[k] = m_xedge;
    end
  endtask

  task automatic check_cycle(input int k);
    chk($sformatf("busy@%0d", k), 32'(busy), 32'(e_busy[k]));
    chk($sformatf("done@%0d", k), 32'(done), 32'(e_done[k]));
    chk($sformatf("w_ready@%0d", k), 32'(w_ready), 32'(e_wrdy[k]));
    chk($sformatf("x_ready@%0d", k), 32'(x_ready), 32'(e_xrdy[k]));
    chk($sformatf("cfg_valid@%0d", k), 32'(cfg_valid), 32'(e_cfgv[k]));
    chk($sformatf("cfg_addr@%0d", k), 32'(cfg_addr), 32'(e_addr[k]));
    chk($sformatf("cfg_data@%0d", k), 32'(cfg_data), 32'(e_data[k]));
    chk($sformatf("global_state@%0d", k), 32'(global_state), 32'(e_gs[k]));
    chk($sformatf("x_edge@%0d", k), 32'(x_edge), 32'(e_xedge[k]));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_w_ready"}, 32'(w_ready), 0);
    chk({tag, "_x_ready"}, 32'(x_ready), 0);
    chk({tag, "_cfg_valid"}, 32'(cfg_valid), 0);
    chk({tag, "_cfg_addr"}, 32'(cfg_addr), 0);
    chk({tag, "_cfg_data"}, 32'(cfg_data), 0);
    chk({tag, "_global_state"}, 32'(global_state), 0);
    chk({tag, "_x_edge"}, 32'(x_edge), 0);
  endtask

  // One pass driven from the model's schedule. chained: this pass's start cycle is the
  // previous pass's done cycle. abort: pull reset in the first MAC output cycle.
  task automatic run_pass(input bit reuse, input bit hold, input bit chained, input int stall,
                          input bit abort);
    int len, ab;
    build_model(reuse, stall, len);
    ab = -1;
    if (abort) for (int k = 0; k <= len; k++) if (ab < 0 && e_gs[k] == 2'd2) ab = k;
    for (int k = 0; k <= len; k++) begin
      if (!(chained && k == 0)) begin @(posedge clk); #1; end
      start = (k == 0) || hold; reuse_w = reuse;
      w_valid = wv[k]; w_data = wd[k]; x_valid = xv[k]; x_data = xd[k];
      if (k == ab) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1; start = 0; w_valid = 0; x_valid = 0;
        repeat (4) begin
          @(negedge clk);
          chk("abort_no_done", 32'(done), 0);
          chk("abort_idle_busy", 32'(busy), 0);
        end
        m_addr = '0; m_data = '0; m_xedge = '0;
        return;
      end
      @(negedge clk);
      if (!(chained && k == 0)) check_cycle(k);
    end
    if (!hold) begin
      @(posedge clk); #1;
      start = 0; w_valid = 0; x_valid = 0;
      @(negedge clk);
      check_cycle(len + 1);
    end
  endtask

  vec_t tbl [13];

  initial begin
    rst_n = 1'b0; start = 0; reuse_w = 0; w_valid = 0; x_valid = 0; w_data = 0; x_data = 0;
    m_addr = '0; m_data = '0; m_xedge = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // start, no stalls: weights 1..4, x beats {5,6} and {7,8}
    tbl[0]  = mk(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 16'h0000);
    tbl[1]  = mk(0, 1, 1, 0, 16'h0000, 1, 0, 1, 0, 0, 8'h00, 0, 0, 16'h0000);
    tbl[2]  = mk(0, 1, 2, 0, 16'h0000, 1, 0, 1, 0, 1, 8'h00, 1, 0, 16'h0000);
    tbl[3]  = mk(0, 1, 3, 0, 16'h0000, 1, 0, 1, 0, 1, 8'h01, 2, 0, 16'h0000);
    tbl[4]  = mk(0, 1, 4, 0, 16'h0000, 1, 0, 1, 0, 1, 8'h10, 3, 0, 16'h0000);
    tbl[5]  = mk(0, 0, 0, 1, 16'h0605, 1, 0, 0, 1, 1, 8'h11, 4, 0, 16'h0000);
    tbl[6]  = mk(0, 0, 0, 1, 16'h0807, 1, 0, 0, 1, 0, 8'h11, 4, 1, 16'h0605);
    tbl[7]  = mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 8'h11, 4, 1, 16'h0807);
    tbl[8]  = mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 8'h11, 4, 3, 16'h0807);
    tbl[9]  = mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 8'h11, 4, 2, 16'h0807);
    tbl[10] = mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 8'h11, 4, 2, 16'h0807);
    tbl[11] = mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 8'h11, 4, 0, 16'h0807);
    tbl[12] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 8'h11, 4, 0, 16'h0807);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      start = tbl[i].s; reuse_w = 0;
      w_valid = tbl[i].wv; w_data = tbl[i].wd; x_valid = tbl[i].xv; x_data = tbl[i].xd;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_w_ready", i), 32'(w_ready), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_x_ready", i), 32'(x_ready), 32'(tbl[i].xr));
      chk($sformatf("tbl%0d_cfg_valid", i), 32'(cfg_valid), 32'(tbl[i].cv));
      chk($sformatf("tbl%0d_cfg_addr", i), 32'(cfg_addr), 32'(tbl[i].a));
      chk($sformatf("tbl%0d_cfg_data", i), 32'(cfg_data), 32'(tbl[i].cd));
      chk($sformatf("tbl%0d_gs", i), 32'(global_state), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_x_edge", i), 32'(x_edge), 32'(tbl[i].xe));
    end
    m_addr = 8'h11; m_data = 8'd4; m_xedge = 16'h0807;

    // reuse_w pass with no stalls: no weight phase, busy four cycles shorter
    run_pass(1'b1, 1'b0, 1'b0, 0, 1'b0);

    // randomized passes with stalls on both streams
    for (int p = 0; p < 10; p++) begin
      run_pass(1'($urandom_range(1)), 1'b0, 1'b0, (p % 3) * 30, 1'b0);
    end

    // start held high: one pass, next accepted in the done cycle, runs from the cycle after
    run_pass(1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_pass(1'b0, 1'b0, 1'b1, 25, 1'b0);

    // reset during the first MAC cycle, then a normal pass
    run_pass(1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_pass(1'b0, 1'b0, 1'b0, 40, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
